// File: rtl/fixedpointadder_pipe.sv
// Multi-lane pipelined fixed-point adder: exact lane add, rounded arithmetic right shift,
// then saturate or wrap to the output width. Two register stages, valid/ready on both sides.
module fixedpointadder_pipe #(
    parameter int unsigned N    = 4,
    parameter int unsigned BA   = 32,
    parameter int unsigned BB   = 32,
    parameter int unsigned BOUT = 32,
    parameter int unsigned SHW  = 6
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*BA-1:0]   a,
    input  logic [N*BB-1:0]   b,
    input  logic [SHW-1:0]    shift,
    input  logic              sat_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*BOUT-1:0] out,
    output logic [N-1:0]      ovf
);
    localparam int unsigned BS = ((BA > BB) ? BA : BB) + 1;
    localparam int unsigned BR = BS + 1;
    localparam int unsigned KW = $clog2(BS);

    logic                 s1_valid;
    logic signed [BS-1:0] s1_sum [N];
    logic [KW-1:0]        s1_k;
    logic                 s1_sat;
    logic                 s2_valid;

    logic                 s1_adv;
    logic                 s2_adv;
    logic [KW-1:0]        k_c;
    logic signed [BS-1:0] sum_c  [N];
    logic [BOUT-1:0]      lane_out [N];
    logic [N-1:0]         lane_ovf;

    // Global-ready back-propagation: a stage advances when it is empty or its successor advances.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // The shift is clamped on entry so stage 2 only sees the effective amount.
    always_comb begin
        k_c = KW'(BS - 1);
        if (32'(shift) <= BS - 1) begin
            k_c = KW'(shift);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_sum
        assign sum_c[i] = BS'($signed(a[i*BA +: BA])) + BS'($signed(b[i*BB +: BB]));
    end

    // Stage 1: exact sums plus per-beat controls.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_valid <= 1'b0;
            s1_k     <= '0;
            s1_sat   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s1_sum[i] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_k   <= k_c;
                s1_sat <= sat_en;
                for (int i = 0; i < N; i++) begin
                    s1_sum[i] <= sum_c[i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [BR-1:0] ext;
        logic signed [BR-1:0] rnd;
        logic signed [BR-1:0] r;

        // Round half toward +inf: add half an LSB of the result before the arithmetic shift.
        always_comb begin
            ext = BR'(s1_sum[i]);
            rnd = (s1_k == '0) ? '0 : (BR'(1) << (s1_k - KW'(1)));
            r   = (ext + rnd) >>> s1_k;
        end

        if (BOUT >= BR) begin : g_wide
            assign lane_out[i] = BOUT'(r);
            assign lane_ovf[i] = 1'b0;
        end else begin : g_narrow
            logic [BR-BOUT:0] top;
            logic             in_range;
            logic [BOUT-1:0]  clamp;

            // In range exactly when every bit above the output sign bit matches it.
            assign top      = r[BR-1:BOUT-1];
            assign in_range = (&top) || !(|top);
            assign clamp    = r[BR-1] ? {1'b1, {(BOUT-1){1'b0}}} : {1'b0, {(BOUT-1){1'b1}}};

            assign lane_ovf[i] = !in_range;
            assign lane_out[i] = (s1_sat && !in_range) ? clamp : r[BOUT-1:0];
        end
    end

    // Stage 2: output registers; hold while stalled.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            ovf      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                ovf <= lane_ovf;
                for (int i = 0; i < N; i++) begin
                    out[i*BOUT +: BOUT] <= lane_out[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fixedpointadder_pipe.sv
// Self-checking bench for fixedpointadder_pipe: arithmetic lane model plus ordered scoreboard.
module tb_fixedpointadder_pipe;
    localparam int N    = 4;
    localparam int BA   = 16;
    localparam int BB   = 16;
    localparam int BOUT = 8;
    localparam int SHW  = 5;

    logic              clk = 1'b0;
    logic              clr_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*BA-1:0]   a = '0;
    logic [N*BB-1:0]   b = '0;
    logic [SHW-1:0]    shift = '0;
    logic              sat_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N*BOUT-1:0] out;
    logic [N-1:0]      ovf;

    typedef struct packed {
        logic [N*BOUT-1:0] o;
        logic [N-1:0]      v;
    } exp_t;

    exp_t exp_q [$];
    int   cyc_q [$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    bit   held_v = 1'b0;
    logic [N*BOUT-1:0] held_o;
    logic [N-1:0]      held_f;

    fixedpointadder_pipe #(.N(N), .BA(BA), .BB(BB), .BOUT(BOUT), .SHW(SHW)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .shift(shift), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Lane rule in plain integer arithmetic: floor((s + 2^(k-1)) / 2^k), then range/sat/wrap.
    task automatic lane_model(input int av, input int bv, input int sh, input bit sat,
                              output int o, output bit v);
        longint s, r, d, num, w;
        int k;
        s = longint'(av) + longint'(bv);
        k = (sh > 16) ? 16 : sh;
        if (k == 0) r = s;
        else begin
            d   = longint'(1) << k;
            num = s + d / 2;
            r   = num / d;
            if ((num % d) != 0 && num < 0) r = r - 1;
        end
        v = (r > 127) || (r < -128);
        if (sat) o = (r > 127) ? 127 : ((r < -128) ? -128 : int'(r));
        else begin
            w = r % 256;
            if (w < 0) w = w + 256;
            if (w >= 128) w = w - 256;
            o = int'(w);
        end
    endtask

    function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    // Single compare process: stall stability, ordered output check, and expectation capture.
    always @(negedge clk) begin
        exp_t e;
        int   c, o;
        bit   v;
        cyc++;
        if (!clr_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_out", longint'(out), longint'(held_o));
                check("stall_ovf", longint'(ovf), longint'(held_f));
                check("stall_valid", longint'(out_valid), 1);
            end
            held_v = out_valid && !out_ready;
            held_o = out;
            held_f = ovf;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("lane%0d_out", i), longint'($signed(out[i*BOUT +: BOUT])),
                              longint'($signed(e.o[i*BOUT +: BOUT])));
                    end
                    check("ovf", longint'(ovf), longint'(e.v));
                    if (lat_chk) check("latency", longint'(cyc - c), 2);
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < N; i++) begin
                    lane_model(int'($signed(a[i*BA +: BA])), int'($signed(b[i*BB +: BB])),
                               int'(shift), sat_en, o, v);
                    e.o[i*BOUT +: BOUT] = 8'(o);
                    e.v[i] = v;
                end
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [63:0] av, input logic [63:0] bv, input int sh, input bit sat,
                        output int waits);
        int n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        shift = SHW'(sh);
        sat_en = sat;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waits = n;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_empty", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int o, w;
        bit v;

        #1 clr_n = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out", longint'(out), 0);
        check("rst_ovf", longint'(ovf), 0);
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", longint'(in_ready), 1);

        // Hand-computed values pin the lane model.
        lane_model(100, 100, 0, 1'b1, o, v);       check("pin_sat", o, 127);   check("pin_sat_ovf", v, 1);
        lane_model(100, 100, 0, 1'b0, o, v);       check("pin_wrap", o, -56);  check("pin_wrap_ovf", v, 1);
        lane_model(3, 4, 0, 1'b1, o, v);           check("pin_small", o, 7);   check("pin_small_ovf", v, 0);
        lane_model(5, 2, 1, 1'b1, o, v);           check("pin_rnd_pos", o, 4);
        lane_model(-5, -2, 1, 1'b1, o, v);         check("pin_rnd_neg", o, -3);
        lane_model(6, 0, 2, 1'b1, o, v);           check("pin_rnd_sh2", o, 2);
        lane_model(-32768, -32768, 31, 1'b1, o, v); check("pin_sh_clamp", o, -1);
        lane_model(-32768, -32768, 0, 1'b1, o, v); check("pin_neg_sat", o, -128); check("pin_neg_ovf", v, 1);

        // Directed vectors through the DUT.
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(pack4(100, 3, -32768, 0), pack4(100, 4, -32768, 0), 0, 1'b1, w);
        send(pack4(100, 3, -32768, 0), pack4(100, 4, -32768, 0), 0, 1'b0, w);
        send(pack4(5, -5, 100, -1), pack4(2, -2, 100, 0), 1, 1'b1, w);
        send(pack4(6, 7, -6, 32767), pack4(0, 0, 0, 32767), 2, 1'b0, w);
        send(pack4(-32768, 32767, 1, -1), pack4(-32768, 32767, 0, 0), 31, 1'b1, w);
        send(pack4(32767, -32768, 127, -128), pack4(0, 0, 0, 0), 8, 1'b0, w);
        drain();

        // Back-to-back stream: each beat must be accepted at once and emerge two cycles later.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, int'($urandom_range(0, 20)),
                 1'(i % 2), w);
            check("stream_no_wait", w, 0);
        end
        drain();

        // Backpressure: stall the output for 4 cycles while the producer keeps offering.
        lat_chk = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(pack4(10 * i, -3 * i, 200, i), pack4(i, 7, 100, -i), i % 3, 1'(i % 2), w);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(negedge clk);
                check("bp_in_ready_low", longint'(in_ready), 0);
                check("bp_out_valid", longint'(out_valid), 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        lat_chk = 1'b1;
        @(posedge clk);
        #1;
        send(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, 1'b1, w);
        send(pack4(50, 60, 70, 80), pack4(50, 60, 70, 80), 0, 1'b1, w);
        check("pre_reset_valid", longint'(out_valid), 1);
        #1 clr_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out", longint'(out), 0);
        check("midrst_ovf", longint'(ovf), 0);
        exp_q.delete();
        cyc_q.delete();
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        send(pack4(-100, 20, 0, 64), pack4(-100, 30, 0, 64), 0, 1'b0, w);
        drain();

        check("final_queue_empty", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fixedpointadder_pipe.md
# fixedpointadder_pipe

Multi-lane, pipelined fixed-point adder for MVP output scaling. It adds `N` independent signed lane pairs, applies a per-beat arithmetic right shift with round-half-up, then saturates or wraps each lane to the output width. It sits between the MVP result path and the output writer, with valid/ready handshakes on both sides. Sustained throughput is one beat per cycle and latency is 2 cycles.

## Interface
Parameters:
- `N`, 4: number of lanes.
- `BA`, 32: width of each `a` lane (signed).
- `BB`, 32: width of each `b` lane (signed).
- `BOUT`, 32: width of each output lane (signed).
- `SHW`, 6: width of the `shift` port.

Derived: `BS = max(BA,BB)+1`, the exact sum width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `clr_n` in 1: reset; asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat this cycle.
- `a` in `N*BA`: lane i is `a[i*BA +: BA]`, signed.
- `b` in `N*BB`: lane i is `b[i*BB +: BB]`, signed.
- `shift` in `SHW`: right-shift amount; sampled with the beat.
- `sat_en` in 1: 1 = saturate, 0 = wrap (truncate); sampled with the beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `out` out `N*BOUT`: lane i is `out[i*BOUT +: BOUT]`, signed.
- `ovf` out `N`: per-lane overflow flag, aligned with `out`.

## Operation
- A beat is accepted when `in_valid && in_ready`. Output transfers when `out_valid && out_ready`.
- **Stage 1 (S1)** registers, per lane:
  - `sum = sext(a,BS) + sext(b,BS)`. The sum is exact, with no overflow possible.
  - `shift` and `sat_en` alongside the sum.
- **Stage 2 (S2)** computes, per lane:
  - Effective shift: `k = min(shift, BS-1)`.
  - If `k == 0`: `r = sum`.
  - Otherwise: `r = (sext(sum,BS+1) + 2^(k-1)) >>> k`. This is arithmetic shift with round-half-toward-+inf, computed at `BS+1` bits.
  - Range check against `[-2^(BOUT-1), 2^(BOUT-1)-1]`: `ovf[i] = 1` when `r` is outside this range. The flag is independent of `sat_en`.
  - With `sat_en=1`, an out-of-range `r` clamps to the nearest bound.
  - With `sat_en=0`, `out` takes the low `BOUT` bits of `r`.
  - If `BOUT >= BS+1`, `out` is the sign extension of `r` and `ovf` is always 0.
- **Pipeline control** is per-stage valid with global-ready back-propagation:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`, a combinational path from `out_ready`.
- No beat is dropped, duplicated or reordered. Lanes never interact.
- Data registers load only on advance. When a stage holds no valid beat, its data is don't-care.
- Simultaneous accept and emit in the same cycle is legal and sustains one beat per cycle.

## Timing
- **Reset** (`clr_n=0`, asynchronous, takes effect immediately):
  - `s1_valid = s2_valid = 0`, so `out_valid = 0`.
  - `out = 0`, `ovf = 0`.
  - `in_ready` = 1 from the first cycle after reset.
- Reset mid-stream discards all in-flight beats. No output appears until new beats are accepted.
- **Latency**: a beat accepted at edge t appears on `out`/`ovf` with `out_valid=1` after edge t+1. It is visible during cycle t+1 if `out_ready` stayed high.
- **Stall**: while `out_valid && !out_ready`, `out`, `ovf` and `out_valid` hold stable.
  - S1 may still fill if empty.
  - `in_ready` drops once both stages are full.
- `in_ready` may rise in the same cycle `out_ready` rises.
- The upstream may deassert `in_valid` freely. The block makes no assumption about upstream `valid` stability.

## Test plan
Bench parameters: `N=4`, `BA=BB=16`, `BOUT=8`, `SHW=5`, with `out_ready=1` unless stated.
- **Saturate vs wrap**: lane0 `a=100, b=100, shift=0`.
  - `sat_en=1` → `out=127`, `ovf[0]=1`.
  - `sat_en=0` → `out=-56`, `ovf[0]=1`.
  - Lane1 `a=3, b=4` → `7`, `ovf[1]=0`.
- **Rounding**, `shift=1`:
  - `5+2` → `4`.
  - `-5+(-2)` → `-3`.
  - `shift=2`, `6+0` → `2`.
  - `shift=31` (clamped to 16), `-32768+(-32768)` → `-1`.
- **Negative extreme**: `a=b=-32768, shift=0, sat_en=1` → `-128`, `ovf=1`.
- **Throughput/latency**: 8 back-to-back beats. The first `out_valid` appears 2 cycles after the first accept, followed by 8 consecutive valid cycles carrying the expected values in order.
- **Backpressure**: stream 6 beats and hold `out_ready=0` for 4 cycles mid-stream.
  - `out` stays stable while stalled.
  - `in_ready` goes low after 2 beats are buffered.
  - All 6 results arrive in order with no loss or duplication.
- **Reset mid-stream**: pulse `clr_n` low asynchronously with 2 beats in flight.
  - `out_valid`, `out` and `ovf` go to 0 immediately.
  - No stale beat is emitted after release.
  - The next accepted beat emerges after 2 cycles with the correct value.
